mem_wb_stage: RTL

Memory stage of the 64-bit five-stage pipeline, including the MEM/WB pipeline register. It consumes the EX/MEM register outputs and resolves the branch decision. It performs doubleword loads and stores against an internal data memory with fixed multi-cycle latency, stalling upstream while an access is in flight. It then registers results for write-back.

---
 rtl/mem_wb_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB pipeline register for the 64-bit pipeline.
// Resolves branches, runs multi-cycle doubleword loads/stores to local data memory.
module mem_wb_stage #(
    parameter int MEM_DEPTH   = 64,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_in,
    input  logic [1:0]  wb_in,
    input  logic [2:0]  m_in,
    input  logic [63:0] alu_result_in,
    input  logic [63:0] write_data_in,
    input  logic [63:0] branch_target_in,
    input  logic        zero_in,
    input  logic [4:0]  rd_in,
    output logic        pc_src,
    output logic [63:0] branch_target_out,
    output logic        stall,
    output logic [1:0]  wb_out,
    output logic [63:0] read_data_out,
    output logic [63:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        misaligned_out
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Captured memory operation, held for the whole access
    logic [63:0]     addr_q, addr_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [1:0]      wbc_q, wbc_d;
    logic [1:0]      mc_q, mc_d;
    logic [4:0]      rdc_q, rdc_d;

    // MEM/WB register
    logic [1:0]      wb_q, wb_d;
    logic [63:0]     rdata_q, rdata_d;
    logic [63:0]     alu_q, alu_d;
    logic [4:0]      rd_q, rd_d;
    logic            mis_q, mis_d;

    logic [63:0]     mem_q [MEM_DEPTH];

    logic            mem_op;
    logic            fire;
    logic            mis_w;
    logic            rd_en;
    logic            we;
    logic [AW-1:0]   idx;

    assign mem_op = valid_in & (m_in[1] | m_in[0]);
    assign fire   = (state_q == ACCESS) && (cnt_q == '0);
    assign mis_w  = addr_q[2:0] != 3'b000;
    assign idx    = addr_q[AW+2:3];
    assign rd_en  = mc_q[1] & ~mc_q[0] & ~mis_w;
    assign we     = fire & mc_q[0] & ~mis_w;

    assign pc_src = valid_in & m_in[2] & zero_in & (state_q == IDLE);
    assign branch_target_out = branch_target_in;

    assign stall = ((state_q == IDLE) & mem_op)
                 | ((state_q == ACCESS) & (cnt_q != '0));

    assign wb_out         = wb_q;
    assign read_data_out  = rdata_q;
    assign alu_result_out = alu_q;
    assign rd_out         = rd_q;
    assign misaligned_out = mis_q;

    // Next-state: access sequencing and what MEM/WB loads this edge
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wbc_d   = wbc_q;
        mc_d    = mc_q;
        rdc_d   = rdc_q;
        wb_d    = 2'b00;
        rdata_d = '0;
        alu_d   = '0;
        rd_d    = '0;
        mis_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op) begin
                    addr_d  = alu_result_in;
                    wdata_d = write_data_in;
                    wbc_d   = wb_in;
                    mc_d    = m_in[1:0];
                    rdc_d   = rd_in;
                    cnt_d   = CNT_INIT;
                    state_d = ACCESS;
                end else begin
                    wb_d  = valid_in ? wb_in : 2'b00;
                    alu_d = alu_result_in;
                    rd_d  = rd_in;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = IDLE;
                    wb_d    = wbc_q;
                    alu_d   = addr_q;
                    rd_d    = rdc_q;
                    mis_d   = mis_w;
                    rdata_d = rd_en ? mem_q[idx] : '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer, capture and MEM/WB registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wbc_q   <= '0;
            mc_q    <= '0;
            rdc_q   <= '0;
            wb_q    <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            rd_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wbc_q   <= wbc_d;
            mc_q    <= mc_d;
            rdc_q   <= rdc_d;
            wb_q    <= wb_d;
            rdata_q <= rdata_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
            mis_q   <= mis_d;
        end
    end

    // Data memory: cleared on reset, store commits on the final access edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[idx] <= wdata_q;
        end
    end

endmodule
